branch_resolve_bht: RTL and testbench

//   Parametrised next-generation branch unit. Resolves branch/jump outcome in EX from ALU flags.

---
 rtl/branch_resolve_bht.sv | 142 ++++++++++++++
 tb/tb_branch_resolve_bht.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_bht.sv
// Branch resolution unit: resolves control transfers in EX from ALU flags, trains a
// table of 2-bit saturating counters for fetch prediction, and redirects fetch on mispredict.
module branch_resolve_bht #(
  parameter int         XLEN         = 32,
  parameter int         BHT_ENTRIES  = 64,
  parameter logic [1:0] CTR_INIT     = 2'b01,
  parameter int         FLUSH_CYCLES = 2,
  parameter int         CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [XLEN-1:0]  res_pc,
  input  logic [6:0]       res_opcode,
  input  logic [2:0]       res_funct3,
  input  logic             res_cf,
  input  logic             res_zf,
  input  logic             res_of,
  input  logic             res_sf,
  input  logic             res_pred_taken,
  input  logic [XLEN-1:0]  res_target,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [FL_W-1:0] fl_cnt, fl_cnt_nxt;
  logic [1:0]      ctr [BHT_ENTRIES];

  logic [IDX_W-1:0] pred_idx, res_idx;
  logic             accept, is_jump, is_cond, cond_true, taken;
  logic             counted, update, mispredict;
  logic             unused_pred_pc_bits;

  assign pred_idx = pred_pc[IDX_W+1:2];
  assign res_idx  = res_pc[IDX_W+1:2];
  assign unused_pred_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

  // Outcome decode; funct3 010/011 are not branches and fall out of is_cond.
  always_comb begin
    cond_true = 1'b0;
    case (res_funct3)
      3'b000:  cond_true = res_zf;
      3'b001:  cond_true = ~res_zf;
      3'b100:  cond_true = (res_sf != res_of);
      3'b101:  cond_true = (res_sf == res_of);
      3'b110:  cond_true = ~res_cf;
      3'b111:  cond_true = res_cf;
      default: cond_true = 1'b0;
    endcase
  end

  assign accept     = res_valid && (state == RUN);
  assign is_jump    = (res_opcode == OP_JAL) || (res_opcode == OP_JALR);
  assign is_cond    = (res_opcode == OP_BRANCH) && (res_funct3[2:1] != 2'b01);
  assign taken      = is_jump || (is_cond && cond_true);
  assign counted    = accept && (is_jump || is_cond);
  assign update     = accept && is_cond;
  assign mispredict = counted && (taken != res_pred_taken);

  // NOTE: the counter table must come out of reset at CTR_INIT, so it is built from
  // resettable flops rather than a RAM macro; every sequential block uses <= only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else if (update) begin
      if (taken && ctr[res_idx] != 2'b11)
        ctr[res_idx] <= ctr[res_idx] + 2'd1;
      else if (!taken && ctr[res_idx] != 2'b00)
        ctr[res_idx] <= ctr[res_idx] - 2'd1;
    end
  end

  // Reads the table before this edge's update, giving the pre-update value on a collision.
  always_ff @(posedge clk) begin
    if (rst) pred_taken <= 1'b0;
    else     pred_taken <= pred_valid && ctr[pred_idx][1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      redirect <= mispredict;
      if (mispredict) begin
        redirect_pc <= taken ? res_target : res_pc + XLEN'(4);
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
      if (counted) branch_cnt <= branch_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      fl_cnt <= '0;
    end else begin
      state  <= state_nxt;
      fl_cnt <= fl_cnt_nxt;
    end
  end

  // NOTE: defaults first so no path through this block can infer a latch.
  always_comb begin
    state_nxt  = state;
    fl_cnt_nxt = fl_cnt;
    case (state)
      RUN: begin
        if (mispredict) begin
          state_nxt  = FLUSH;
          fl_cnt_nxt = FL_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (fl_cnt == '0) state_nxt = RUN;
        else              fl_cnt_nxt = fl_cnt - FL_W'(1);
      end
      default: state_nxt = RUN;
    endcase
  end

  assign flush = (state == FLUSH);

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Scoreboard bench for branch_resolve_bht: a driver pushes reference-model expectations,
// a monitor pops one per clock and compares against the DUT outputs.
module tb_branch_resolve_bht;

  localparam int XLEN = 32;
  localparam int N    = 64;
  localparam int FLC  = 2;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011, ALU = 7'b0110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pred_valid, pred_taken, res_valid;
  logic [31:0] pred_pc, res_pc, res_target, redirect_pc, branch_cnt, mispred_cnt;
  logic [6:0]  res_opcode;
  logic [2:0]  res_funct3;
  logic        res_cf, res_zf, res_of, res_sf, res_pred_taken, redirect, flush;

  branch_resolve_bht #(
    .XLEN(XLEN), .BHT_ENTRIES(N), .CTR_INIT(2'b01), .FLUSH_CYCLES(FLC), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .res_opcode(res_opcode), .res_funct3(res_funct3),
    .res_cf(res_cf), .res_zf(res_zf), .res_of(res_of), .res_sf(res_sf),
    .res_pred_taken(res_pred_taken), .res_target(res_target),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    bit          was_rst;
    bit          pred;
    bit          redir;
    logic [31:0] rpc;
    bit          fl;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  bit   done = 0;

  // Reference model: counters as plain integers 0..3, flush as cycles remaining.
  int          m_ctr[N];
  int          m_flush;
  logic [31:0] m_bc, m_mc;
  logic [31:0] cur_a, cur_b;

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit cond_taken(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Drives the resolve port; ALU flags are derived from the compare operands a - b.
  task automatic set_res(bit v, logic [31:0] pc, logic [6:0] op, logic [2:0] f3,
                         logic [31:0] a, logic [31:0] b, bit pt, logic [31:0] tgt);
    logic [32:0] d;
    d = {1'b0, a} - {1'b0, b};
    res_valid = v; res_pc = pc; res_opcode = op; res_funct3 = f3;
    res_pred_taken = pt; res_target = tgt;
    cur_a = a; cur_b = b;
    res_cf = ~d[32];
    res_zf = (a == b);
    res_sf = d[31];
    res_of = (a[31] != b[31]) && (d[31] != a[31]);
  endtask

  task automatic step();
    exp_t e;
    int   pi, ri;
    bit   is_j, is_c, tk;
    e = '{default: 0};
    if (rst) begin
      foreach (m_ctr[i]) m_ctr[i] = 1;
      m_flush = 0; m_bc = 0; m_mc = 0;
      e.was_rst = 1;
    end else begin
      pi = int'((pred_pc >> 2) % N);
      e.pred = pred_valid && (m_ctr[pi] >= 2);
      if (m_flush > 0) begin
        m_flush--;
      end else if (res_valid) begin
        is_j = (res_opcode == JAL) || (res_opcode == JALR);
        is_c = (res_opcode == BR) && !(res_funct3 == 3'd2 || res_funct3 == 3'd3);
        if (is_j || is_c) begin
          tk = is_j ? 1'b1 : cond_taken(res_funct3, cur_a, cur_b);
          m_bc++;
          if (is_c) begin
            ri = int'((res_pc >> 2) % N);
            if (tk) m_ctr[ri] = (m_ctr[ri] < 3) ? m_ctr[ri] + 1 : 3;
            else    m_ctr[ri] = (m_ctr[ri] > 0) ? m_ctr[ri] - 1 : 0;
          end
          if (tk != res_pred_taken) begin
            m_mc++;
            e.redir = 1;
            e.rpc   = tk ? res_target : res_pc + 32'd4;
            m_flush = FLC;
          end
        end
      end
    end
    e.fl = (m_flush > 0);
    e.bc = m_bc;
    e.mc = m_mc;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    res_valid = 0; pred_valid = 0;
    repeat (n) step();
  endtask

  task automatic lookup(logic [31:0] pc);
    res_valid = 0; pred_valid = 1; pred_pc = pc;
    step();
    pred_valid = 0;
    step();
  endtask

  always @(posedge clk) begin
    #1;
    if (!done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow actual=empty expected=entry at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("pred_taken", 64'(pred_taken), 64'(mon_e.pred));
        check("redirect", 64'(redirect), 64'(mon_e.redir));
        check("flush", 64'(flush), 64'(mon_e.fl));
        check("branch_cnt", 64'(branch_cnt), 64'(mon_e.bc));
        check("mispred_cnt", 64'(mispred_cnt), 64'(mon_e.mc));
        if (mon_e.redir || mon_e.was_rst)
          check("redirect_pc", 64'(redirect_pc), 64'(mon_e.rpc));
      end
    end
  end

  initial begin
    logic [6:0]  op;
    logic [31:0] pc, a, b;
    int          r;

    rst = 1; pred_valid = 0; pred_pc = 0;
    set_res(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    rst = 0;

    // BEQ taken four times at one PC trains the counter to strongly taken.
    repeat (4) begin
      set_res(1, 32'h40, BR, 3'd0, 32'd5, 32'd5, 0, 32'h80);
      step();
      idle(3);
    end
    lookup(32'h40);

    // BNE not taken against a taken prediction: redirect to fall-through.
    set_res(1, 32'h100, BR, 3'd1, 32'd7, 32'd7, 1, 32'h300);
    step();
    idle(3);

    // JAL mispredict, then a BEQ mispredict inside the flush window.
    set_res(1, 32'h44, JAL, 3'd0, 0, 0, 0, 32'h2000);
    step();
    set_res(1, 32'h48, BR, 3'd0, 32'd1, 32'd1, 0, 32'h90);
    step();
    idle(3);
    lookup(32'h44);
    lookup(32'h48);

    // Signed/unsigned compares, each correctly predicted, then a non-branch opcode.
    set_res(1, 32'h10, BR, 3'd4, 32'hFFFF_FFFF, 32'h0, 1, 32'h500); step();
    set_res(1, 32'h14, BR, 3'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, 32'h500); step();
    set_res(1, 32'h18, BR, 3'd6, 32'd1, 32'd2, 1, 32'h500); step();
    set_res(1, 32'h1C, BR, 3'd7, 32'd1, 32'd2, 0, 32'h500); step();
    set_res(1, 32'h20, ALU, 3'd0, 32'd3, 32'd3, 1, 32'h500); step();
    set_res(1, 32'h24, BR, 3'd2, 32'd3, 32'd3, 1, 32'h500); step();
    idle(1);

    // Same-index lookup and update in one cycle returns the pre-update counter.
    set_res(1, 32'h200, BR, 3'd0, 32'd9, 32'd9, 1, 32'h600);
    pred_valid = 1; pred_pc = 32'h200;
    step();
    lookup(32'h200);

    // Fall-through wraps at the top of the address space.
    set_res(1, 32'hFFFF_FFFC, BR, 3'd1, 32'd4, 32'd4, 1, 32'h0);
    step();
    idle(3);

    // Reset in the middle of a flush window.
    set_res(1, 32'h60, BR, 3'd0, 32'd2, 32'd2, 0, 32'h700);
    step();
    rst = 1; res_valid = 0;
    step();
    rst = 0;
    idle(1);
    lookup(32'h40);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      r = $urandom_range(0, 9);
      op = (r == 0) ? JAL : (r == 1) ? JALR : (r <= 7) ? BR : (r == 8) ? ALU : 7'($urandom);
      a = $urandom;
      r = $urandom_range(0, 2);
      b = (r == 0) ? a : (r == 1) ? $urandom : {a[31:1], ~a[0]};
      pc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_07FC);
      set_res($urandom_range(0, 9) < 7, pc, op, 3'($urandom), a, b,
              1'($urandom), $urandom & 32'hFFFF_FFFC);
      pred_valid = ($urandom_range(0, 9) < 6);
      pred_pc = $urandom_range(0, 1) ? pc : ($urandom & 32'h0000_07FC);
      step();
    end
    rst = 0;
    idle(4);

    done = 1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
